// File: rtl/acc_pkg.sv
// Shared accelerator constants, result-reader state encoding and byte-lane helper.
package acc_pkg;

    localparam int unsigned IMG_W          = 352;
    localparam int unsigned IMG_H          = 288;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORDS_PER_IMG  = IMG_W * IMG_H / BYTES_PER_WORD;
    localparam int unsigned RESULT_BASE    = 25344;
    localparam int unsigned ADDR_W         = 16;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned PIX_W          = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_FIN,
        RD_REQ,
        RD_WAIT,
        SEND,
        DONE
    } state_t;

    // Little-endian byte lane select: idx 0 is bits [7:0].
    function automatic logic [PIX_W-1:0] byte_sel(input logic [DATA_W-1:0] w,
                                                  input logic [1:0]        idx);
        return w[{idx, 3'b000} +: PIX_W];
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Turns one loaded 32-bit word into four bytes on a valid/ready stream, LSB first.
module word_serializer
    import acc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              word_done_c
);

    logic [DATA_W-1:0] hold;
    logic [1:0]        idx;
    logic              xfer_c;

    assign xfer_c      = pix_valid && pix_ready;
    assign word_done_c = xfer_c && (idx == 2'd3);

    // pix_data only moves on a load or an accepted byte, so it is stable under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            idx       <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
        end else if (load) begin
            hold      <= word;
            idx       <= '0;
            pix_data  <= word[PIX_W-1:0];
            pix_valid <= 1'b1;
        end else if (xfer_c) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
                pix_valid <= 1'b0;
            end else begin
                pix_data <= byte_sel(hold, idx + 2'd1);
            end
        end
    end

endmodule

// File: rtl/result_reader.sv
// Launches one accelerator job, then streams the result image out of memory as bytes
// while accumulating a 32-bit checksum of every byte delivered.
module result_reader
    import acc_pkg::*;
#(
    parameter int unsigned BASE_ADDR = RESULT_BASE,
    parameter int unsigned NUM_WORDS = WORDS_PER_IMG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    output logic              start,
    input  logic              finish,
    output logic [ADDR_W-1:0] addr,
    output logic              en,
    output logic              we,
    output logic [DATA_W-1:0] dataW,
    input  logic [DATA_W-1:0] dataR,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    // The whole image must sit inside the 16-bit word address space.
    if (NUM_WORDS == 0 || (64'(BASE_ADDR) + 64'(NUM_WORDS)) > (64'(1) << ADDR_W)) begin : g_bad_params
        $error("result_reader: BASE_ADDR/NUM_WORDS exceed the 16-bit address space");
    end

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] word_cnt, cnt_nxt, addr_nxt;
    logic [DATA_W-1:0] csum_nxt;
    logic              start_nxt, en_nxt, busy_nxt, done_nxt;
    logic              load_c, word_done_c, xfer_c;

    assign we     = 1'b0;
    assign dataW  = '0;
    assign xfer_c = pix_valid && pix_ready;

    word_serializer u_ser (
        .clk        (clk),
        .rst_n      (reset),
        .load       (load_c),
        .word       (dataR),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .word_done_c(word_done_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = word_cnt;
        addr_nxt  = addr;
        csum_nxt  = checksum;
        load_c    = 1'b0;
        if (xfer_c) csum_nxt = checksum + DATA_W'(pix_data);
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                    csum_nxt  = '0;
                end
            end
            START:    state_nxt = WAIT_FIN;
            WAIT_FIN: begin
                if (finish) begin
                    state_nxt = RD_REQ;
                    addr_nxt  = BASE_A + word_cnt;
                end
            end
            RD_REQ:   state_nxt = RD_WAIT;
            RD_WAIT: begin
                load_c    = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                if (word_done_c) begin
                    if (word_cnt == LAST_WORD) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt   = word_cnt + ADDR_W'(1);
                        addr_nxt  = BASE_A + word_cnt + ADDR_W'(1);
                        state_nxt = RD_REQ;
                    end
                end
            end
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        start_nxt = (state_nxt == START) || (state_nxt == WAIT_FIN);
        en_nxt    = (state_nxt == RD_REQ);
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt <= '0;
            addr     <= '0;
            checksum <= '0;
            start    <= 1'b0;
            en       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            word_cnt <= cnt_nxt;
            addr     <= addr_nxt;
            checksum <= csum_nxt;
            start    <= start_nxt;
            en       <= en_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: directed, stall, disturbance, mid-job reset and randomized jobs.
module tb_result_reader;
    import acc_pkg::*;

    localparam int unsigned TB_BASE  = 65534;
    localparam int unsigned TB_WORDS = 2;

    logic        clk = 1'b0;
    logic        reset, go, finish, pix_ready;
    logic        start, en, we, pix_valid, busy, done;
    logic [15:0] addr;
    logic [31:0] dataW, dataR, checksum;
    logic [7:0]  pix_data;

    result_reader #(.BASE_ADDR(TB_BASE), .NUM_WORDS(TB_WORDS)) dut (
        .clk(clk), .reset(reset), .go(go), .start(start), .finish(finish),
        .addr(addr), .en(en), .we(we), .dataW(dataW), .dataR(dataR),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rn       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory holding the result image.
    logic [31:0] mem [TB_WORDS];
    int          mem_off;
    always @(posedge clk) begin
        if (en) begin
            mem_off = int'(addr) - int'(TB_BASE);
            if (mem_off >= 0 && mem_off < int'(TB_WORDS)) dataR <= mem[mem_off];
            else                                          dataR <= 32'hDEAD_BEEF;
        end
    end

    // Observation state filled by the monitor.
    logic [7:0]  got_q [$];
    logic [15:0] addr_q[$];
    int          done_cnt, done_cyc, first_valid_cyc, stall_err;
    int          const_err = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data;

    always @(negedge clk) begin
        if (we !== 1'b0 || dataW !== 32'h0) const_err++;
        if (reset !== 1'b1) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (pix_valid !== 1'b1 || pix_data !== prev_data)) stall_err++;
            if (pix_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pix_valid === 1'b1 && pix_ready === 1'b1) got_q.push_back(pix_data);
            if (en === 1'b1) addr_q.push_back(addr);
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = (pix_valid === 1'b1) && (pix_ready === 1'b0);
            prev_data  = pix_data;
        end
    end

    // Reference model: bytes leave LSB first, word by word; checksum is their plain sum.
    logic [7:0]  exp_b[$];
    logic [31:0] exp_sum;

    task automatic build_expected();
        exp_b.delete();
        exp_sum = 0;
        for (int w = 0; w < int'(TB_WORDS); w++) begin
            for (int b = 0; b < 4; b++) begin
                logic [7:0] v;
                v = 8'((mem[w] >> (8 * b)) & 32'hFF);
                exp_b.push_back(v);
                exp_sum = exp_sum + 32'(v);
            end
        end
    endtask

    function automatic logic ready_val(input int mode, input int n);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (n % 3 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input int mode);
        @(posedge clk);
        #1;
        pix_ready = ready_val(mode, rn);
        rn++;
    endtask

    task automatic clear_mon();
        got_q.delete();
        addr_q.delete();
        done_cnt        = 0;
        done_cyc        = -1;
        first_valid_cyc = -1;
        stall_err       = 0;
    endtask

    // Drives one full job; observations are left in the monitor variables.
    task automatic run_job(input int fin_delay, input int mode, input bit disturb,
                           output int fin_cyc, output logic st_fin, output logic st_after,
                           output bit timed_out);
        step(mode);
        go = 1'b1;
        clear_mon();
        step(mode);
        go = 1'b0;
        repeat (fin_delay) step(mode);
        finish  = 1'b1;
        fin_cyc = cyc;
        @(negedge clk);
        st_fin = start;
        step(mode);
        finish = 1'b0;
        @(negedge clk);
        st_after  = start;
        timed_out = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step(mode);
            go     = disturb && pix_valid;
            finish = disturb && pix_valid;
            @(negedge clk);
            if (done_cnt > 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        go     = 1'b0;
        finish = 1'b0;
        repeat (3) step(mode);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [60:0] snap;
        reset = 1'b0; go = 1'b0; finish = 1'b0; pix_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        snap = {start, en, pix_valid, done, busy, addr, pix_data, checksum};
        n_checks++;
        if (snap !== '0) $display("FAIL reset_outputs: got %h required 0", snap);
        else n_pass++;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_finish_in_idle();
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            step(0);
            finish = (i < 3);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || start !== 1'b0 || addr_q.size() != 0)
            $display("FAIL idle_finish: busy=%b start=%b en_pulses=%0d required 0/0/0", busy, start, addr_q.size());
        else n_pass++;
    endtask

    task automatic test_basic(input bit disturb, input string tag);
        int fc, bad; logic sf, sa; bit to;
        mem[0] = 32'h0403_0201;
        mem[1] = 32'h0807_0605;
        build_expected();
        run_job(10, 0, disturb, fc, sf, sa, to);
        n_checks++;
        if (to || sf !== 1'b1 || sa !== 1'b0)
            $display("FAIL %s_handshake: timeout=%b start_at_finish=%b start_after=%b required 0/1/0", tag, to, sf, sa);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < exp_b.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_b[i]) bad++;
        n_checks++;
        if (bad != 0 || got_q.size() != exp_b.size())
            $display("FAIL %s_bytes: %0d wrong, %0d received, required %0d matching", tag, bad, got_q.size(), exp_b.size());
        else n_pass++;
        n_checks++;
        if (checksum !== exp_sum || checksum !== 32'd36) $display("FAIL %s_checksum: got %0d required %0d", tag, checksum, exp_sum);
        else n_pass++;
        n_checks++;
        if (done_cnt != 1 || busy !== 1'b0) $display("FAIL %s_done: pulses=%0d busy=%b required 1/0", tag, done_cnt, busy);
        else n_pass++;
        n_checks++;
        if (first_valid_cyc - fc != 3 || done_cyc - fc != 6 * int'(TB_WORDS) + 1)
            $display("FAIL %s_timing: first_valid=+%0d done=+%0d required +3/+%0d", tag, first_valid_cyc - fc, done_cyc - fc, 6 * TB_WORDS + 1);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < int'(TB_WORDS); i++)
            if (i >= addr_q.size() || addr_q[i] !== 16'(TB_BASE + i)) bad++;
        n_checks++;
        if (bad != 0 || addr_q.size() != int'(TB_WORDS))
            $display("FAIL %s_addr: %0d wrong of %0d en pulses, required %0d", tag, bad, addr_q.size(), TB_WORDS);
        else n_pass++;
    endtask

    task automatic test_stall();
        int fc, bad; logic sf, sa; bit to;
        mem[0] = 32'h0403_0201;
        mem[1] = 32'h0807_0605;
        build_expected();
        rn = 0;
        run_job(10, 1, 1'b0, fc, sf, sa, to);
        bad = 0;
        for (int i = 0; i < exp_b.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_b[i]) bad++;
        n_checks++;
        if (to || bad != 0 || got_q.size() != exp_b.size())
            $display("FAIL stall_bytes: timeout=%b %0d wrong, %0d received, required %0d", to, bad, got_q.size(), exp_b.size());
        else n_pass++;
        n_checks++;
        if (stall_err != 0) $display("FAIL stall_stable: %0d unstable stall cycles, required 0", stall_err);
        else n_pass++;
        n_checks++;
        if (checksum !== 32'd36 || done_cnt != 1) $display("FAIL stall_checksum: got %0d pulses=%0d required 36/1", checksum, done_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_job();
        int fc, bad; logic sf, sa; bit to;
        logic [60:0] snap;
        mem[0] = 32'h1122_3344;
        mem[1] = 32'hA5B6_C7D8;
        build_expected();
        step(0); go = 1'b1; clear_mon();
        step(0); go = 1'b0;
        repeat (4) step(0);
        finish = 1'b1;
        step(0); finish = 1'b0;
        for (int i = 0; i < 50 && got_q.size() < 5; i++) begin
            step(0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        snap = {start, en, pix_valid, done, busy, addr, pix_data, checksum};
        n_checks++;
        if (got_q.size() < 5 || snap !== '0) $display("FAIL midreset_outputs: bytes_seen=%0d got %h required >=5/0", got_q.size(), snap);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) step(0);
        @(negedge clk);
        n_checks++;
        if (done_cnt != 0 || busy !== 1'b0) $display("FAIL midreset_idle: done_pulses=%0d busy=%b required 0/0", done_cnt, busy);
        else n_pass++;
        run_job(3, 0, 1'b0, fc, sf, sa, to);
        bad = 0;
        for (int i = 0; i < exp_b.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_b[i]) bad++;
        n_checks++;
        if (to || bad != 0 || got_q.size() != exp_b.size() || checksum !== exp_sum || done_cnt != 1)
            $display("FAIL midreset_rerun: timeout=%b wrong=%0d count=%0d sum=%h pulses=%0d required 0/0/%0d/%h/1",
                     to, bad, got_q.size(), checksum, done_cnt, exp_b.size(), exp_sum);
        else n_pass++;
    endtask

    task automatic test_random();
        int fc, bad; logic sf, sa; bit to;
        for (int j = 0; j < 20; j++) begin
            for (int w = 0; w < int'(TB_WORDS); w++) mem[w] = $urandom;
            build_expected();
            run_job(int'($urandom_range(1, 12)), 2, 1'b0, fc, sf, sa, to);
            bad = 0;
            for (int i = 0; i < exp_b.size(); i++)
                if (i >= got_q.size() || got_q[i] !== exp_b[i]) bad++;
            n_checks++;
            if (to || bad != 0 || got_q.size() != exp_b.size())
                $display("FAIL rand%0d_bytes: timeout=%b %0d wrong, %0d received, required %0d", j, to, bad, got_q.size(), exp_b.size());
            else n_pass++;
            n_checks++;
            if (checksum !== exp_sum) $display("FAIL rand%0d_checksum: got %h required %h", j, checksum, exp_sum);
            else n_pass++;
            n_checks++;
            if (done_cnt != 1 || stall_err != 0 || addr_q.size() != int'(TB_WORDS))
                $display("FAIL rand%0d_protocol: pulses=%0d stall_err=%0d en_pulses=%0d required 1/0/%0d", j, done_cnt, stall_err, addr_q.size(), TB_WORDS);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_finish_in_idle();
        test_basic(1'b0, "basic");
        test_stall();
        test_basic(1'b1, "disturb");
        test_reset_mid_job();
        test_random();
        n_checks++;
        if (const_err != 0) $display("FAIL write_port: %0d cycles with we/dataW nonzero, required 0", const_err);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
